// File: rtl/wam_pkg.sv
// wam_pkg -- shared definitions for the 3x3 keypad scanner.
//   KEY_ROWS / KEY_COLS / NUM_KEYS : matrix geometry
//   scan_state_e                   : column-scan FSM states
//   key_idx_t, key_idx()           : key index encoding (row*KEY_COLS + col),
//                                    identical to the LED index
//   lowest_key()                   : lowest set index of a key vector
//   col_strobe()                   : active-low strobe pattern for one column
package wam_pkg;

  localparam int KEY_ROWS = 3;
  localparam int KEY_COLS = 3;
  localparam int NUM_KEYS = KEY_ROWS * KEY_COLS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_NEXT,
    ST_FRAME
  } scan_state_e;

  typedef logic [3:0] key_idx_t;

  function automatic key_idx_t key_idx(input int row, input int col);
    return key_idx_t'(row * KEY_COLS + col);
  endfunction

  function automatic key_idx_t lowest_key(input logic [NUM_KEYS-1:0] v);
    key_idx_t idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) idx = key_idx_t'(i);
    return idx;
  endfunction

  function automatic logic [KEY_COLS-1:0] col_strobe(input logic [1:0] col);
    logic [KEY_COLS-1:0] one;
    one = 1;
    return ~(one << col);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if -- key event handshake between scanner and consumer.
//   key_valid : a press event is pending
//   key_code  : index of the pending key (0..8)
//   key_ack   : consumer accepts the pending event
// master = scanner side, slave = consumer side.
interface keypad_scanner_if;
  import wam_pkg::*;

  logic     key_valid;
  key_idx_t key_code;
  logic     key_ack;

  modport master (output key_valid, output key_code, input  key_ack);
  modport slave  (input  key_valid, input  key_code, output key_ack);
endinterface

// File: rtl/keypad_scanner_debouncer.sv
// key_debouncer -- debounced level for one key, advanced once per scan frame.
//   CLOCK_50 : clock            reset : synchronous, active-high
//   update   : frame strobe (counter/level advance only on this cycle)
//   raw      : key closed in the frame just completed
//   state    : debounced level
//   rise     : combinational, high in the update cycle that takes state 0->1
module key_debouncer #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic update,
  input  logic raw,
  output logic state,
  output logic rise
);

  logic [2:0] cnt_q, cnt_d;
  logic       state_q, state_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    rise    = 1'b0;
    if (update) begin
      if (raw == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == 3'(DEBOUNCE_SCANS - 1)) begin
        // this frame is the DEBOUNCE_SCANS-th consecutive disagreement
        state_d = ~state_q;
        cnt_d   = '0;
        rise    = raw;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner -- 3x3 matrix keypad scanner with debounce and press events.
//   CLOCK_50       : clock                  reset : synchronous, active-high
//   key_matrix_row : row sense, active-low  key_matrix_col : column strobes, active-low
//   key_state      : debounced level per key (index row*3+col)
//   key_press      : one-cycle pulse per key on debounced 0->1
//   key_overflow   : sticky, a press event was dropped
//   evt (master)   : key_valid / key_code / key_ack event handshake
// Build option: define KEYPAD_GHOST_REJECT_EN to discard frames with 3+ keys
// closed (possible ghosting); default build applies every frame.
//
// Scan timing: each column is low for SCAN_DIV cycles and columns switch
// directly (one low bit at a time); ST_NEXT is the first dwell cycle of
// columns 1 and 2, ST_SAMPLE the last dwell cycle of every column. One
// ST_FRAME cycle with all columns high closes the frame: 3*SCAN_DIV+1 cycles.
module keypad_scanner
  import wam_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [KEY_ROWS-1:0] key_matrix_row,
  output logic [KEY_COLS-1:0] key_matrix_col,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                key_overflow,
  keypad_scanner_if.master    evt
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_PRELAST = DW'(SCAN_DIV - 2);

  // ---------------- scan FSM ----------------
  scan_state_e         state_q, state_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [KEY_COLS-1:0] col_q, col_d;
  logic [NUM_KEYS-1:0] raw_q, raw_d;
  logic                frame_tick;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_idx_d  = col_idx_q;
    col_d      = col_q;
    raw_d      = raw_q;
    frame_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_DRIVE;
        col_idx_d = 2'd0;
        col_d     = col_strobe(2'd0);
        cnt_d     = '0;
      end
      ST_DRIVE, ST_NEXT: begin
        cnt_d   = cnt_q + DW'(1);
        state_d = (cnt_q == DWELL_PRELAST) ? ST_SAMPLE : ST_DRIVE;
      end
      ST_SAMPLE: begin
        for (int r = 0; r < KEY_ROWS; r++)
          raw_d[key_idx(r, int'(col_idx_q))] = ~key_matrix_row[r];
        cnt_d = '0;
        if (col_idx_q == 2'(KEY_COLS - 1)) begin
          state_d = ST_FRAME;
          col_d   = '1;
        end else begin
          state_d   = ST_NEXT;
          col_idx_d = col_idx_q + 2'd1;
          col_d     = col_strobe(col_idx_q + 2'd1);
        end
      end
      ST_FRAME: begin
        frame_tick = 1'b1;
        state_d    = ST_DRIVE;
        col_idx_d  = 2'd0;
        col_d      = col_strobe(2'd0);
        cnt_d      = '0;
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      col_idx_q <= 2'd0;
      col_q     <= '1;
      raw_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      raw_q     <= raw_d;
    end
  end

  assign key_matrix_col = col_q;

  // ---------------- debouncers ----------------
  logic ghost;
`ifdef KEYPAD_GHOST_REJECT_EN
  assign ghost = ($countones(raw_q) >= 3);
`else
  assign ghost = 1'b0;
`endif

  logic                update;
  logic [NUM_KEYS-1:0] rise_w;

  assign update = frame_tick & ~ghost;

  key_debouncer #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb [NUM_KEYS-1:0] (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .update   (update),
    .raw      (raw_q),
    .state    (key_state),
    .rise     (rise_w)
  );

  // ---------------- press events ----------------
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic                valid_q, valid_d;
  key_idx_t            code_q, code_d;
  logic                ovf_q, ovf_d;

  always_comb begin
    press_d = rise_w;
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    if (|rise_w) begin
      // an ack in the same cycle frees the slot, so the new press wins
      if (!valid_q || evt.key_ack) begin
        valid_d = 1'b1;
        code_d  = lowest_key(rise_w);
        if ((rise_w & (rise_w - 1'b1)) != '0) ovf_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && evt.key_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      press_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign key_press     = press_q;
  assign key_overflow  = ovf_q;
  assign evt.key_valid = valid_q;
  assign evt.key_code  = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner -- self-checking bench for keypad_scanner
// (SCAN_DIV=4, DEBOUNCE_SCANS=2). A timing/arithmetic reference model
// predicts every output each cycle; table vectors and hand sequences add
// fixed expectations for the documented scenarios.
module tb_keypad_scanner;
  import wam_pkg::*;

  localparam int S = 4;
  localparam int D = 2;
  localparam int P = 3 * S + 1;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [8:0] closed   = '0;
  logic [2:0] rows, col;
  logic [8:0] kstate, kpress;
  logic       kovf;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_SCANS(D)) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .key_matrix_row (rows),
    .key_matrix_col (col),
    .key_state      (kstate),
    .key_press      (kpress),
    .key_overflow   (kovf),
    .evt            (kif)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // a closed key pulls its row low while its column is strobed
  always_comb begin
    rows = '1;
    for (int r = 0; r < 3; r++)
      rows[r] = ~|(closed[r*3 +: 3] & ~col);
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_t;
  bit [8:0] m_raw, m_state, m_press;
  int       m_cnt [9];
  bit       m_valid, m_ovf;
  bit [3:0] m_code;

  function automatic bit [2:0] exp_col(input int t);
    int pos;
    if (t == 0) return 3'b111;
    pos = (t - 1) % P;
    if (pos < 3 * S) return ~(3'b001 << (pos / S));
    return 3'b111;
  endfunction

  function automatic bit ghost_frame(input bit [8:0] raw);
`ifdef KEYPAD_GHOST_REJECT_EN
    return $countones(raw) >= 3;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    bit [8:0] r;
    int pos;
    r = '0;
    if (reset) begin
      m_t = 0; m_raw = '0; m_state = '0; m_press = '0;
      m_valid = 0; m_ovf = 0; m_code = '0;
      for (int k = 0; k < 9; k++) m_cnt[k] = 0;
      return;
    end
    if (m_t > 0) begin
      pos = (m_t - 1) % P;
      if (pos < 3 * S && pos % S == S - 1)
        for (int rr = 0; rr < 3; rr++) m_raw[rr*3 + pos/S] = closed[rr*3 + pos/S];
      if (pos == 3 * S && !ghost_frame(m_raw)) begin
        for (int k = 0; k < 9; k++) begin
          if (m_raw[k] == m_state[k]) m_cnt[k] = 0;
          else begin
            m_cnt[k]++;
            if (m_cnt[k] == D) begin
              m_state[k] = ~m_state[k];
              m_cnt[k] = 0;
              if (m_state[k]) r[k] = 1'b1;
            end
          end
        end
      end
    end
    if (r != 0) begin
      if (!m_valid || kif.key_ack) begin
        m_valid = 1'b1;
        for (int k = 8; k >= 0; k--) if (r[k]) m_code = 4'(k);
        if ($countones(r) > 1) m_ovf = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && kif.key_ack) begin
      m_valid = 1'b0;
    end
    m_press = r;
    m_t++;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    chk("outputs", {col, kstate, kpress, kif.key_valid, kif.key_code, kovf},
                   {exp_col(m_t), m_state, m_press, m_valid, m_code, m_ovf});
    chk("col_low_count", 32'($countones(~col) > 1), 32'd0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    kif.key_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [8:0] closed;
    logic [8:0] e_state;
    logic       e_valid;
    logic [3:0] e_code;
    logic       e_ovf;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n;
    kif.key_ack = 1'b0;
    tbl[0] = '{9'h000, 9'h000, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{9'h010, 9'h010, 1'b1, 4'd4, 1'b0};
    tbl[2] = '{9'h022, 9'h022, 1'b1, 4'd1, 1'b1};
    tbl[3] = '{9'h004, 9'h004, 1'b1, 4'd2, 1'b0};
    tbl[4] = '{9'h100, 9'h100, 1'b1, 4'd8, 1'b0};
`ifdef KEYPAD_GHOST_REJECT_EN
    tbl[5] = '{9'h00B, 9'h000, 1'b0, 4'd0, 1'b0};
`else
    tbl[5] = '{9'h00B, 9'h00B, 1'b1, 4'd0, 1'b1};
`endif

    // reset state
    do_reset();
    chk("reset_col", col, 3'b111);
    chk("reset_outs", {kstate, kpress, kif.key_valid, kif.key_code, kovf}, '0);

    // table: hold a pattern for 4 frames from reset, check the settled outputs
    for (int i = 0; i < 6; i++) begin
      do_reset();
      closed = tbl[i].closed;
      run(4 * P);
      chk("tbl_state", kstate, tbl[i].e_state);
      chk("tbl_valid", kif.key_valid, tbl[i].e_valid);
      chk("tbl_code", kif.key_code, tbl[i].e_code);
      chk("tbl_ovf", kovf, tbl[i].e_ovf);
      closed = '0;
    end

    // key 4: press pulse, event, latency bound, ack
    do_reset();
    closed = 9'h010;
    n = 0;
    while (kpress == '0 && n < (D + 1) * P + 2) begin step(); n++; end
    chk("a_press", kpress, 9'h010);
    chk("a_latency_ok", 32'(n <= (D + 1) * P + 2), 32'd1);
    chk("a_valid", kif.key_valid, 1'b1);
    chk("a_code", kif.key_code, 4'd4);
    step();
    chk("a_press_once", kpress, 9'h000);
    kif.key_ack = 1'b1;
    step();
    kif.key_ack = 1'b0;
    chk("a_ack_clears", kif.key_valid, 1'b0);
    run(P);

    // key 6 closed for exactly one frame: filtered out
    do_reset();
    closed = 9'h040;
    run(P);
    closed = '0;
    run(3 * P);
    chk("b_state", kstate, 9'h000);
    chk("b_valid", kif.key_valid, 1'b0);

    // key 2 then key 7 without ack: overflow sticky until reset
    do_reset();
    closed = 9'h004;
    run(3 * P);
    closed = '0;
    run(3 * P);
    closed = 9'h080;
    run(3 * P);
    chk("c_code", kif.key_code, 4'd2);
    chk("c_ovf", kovf, 1'b1);
    kif.key_ack = 1'b1;
    step();
    kif.key_ack = 1'b0;
    chk("c_ovf_after_ack", kovf, 1'b1);
    closed = '0;
    do_reset();
    chk("c_ovf_reset", kovf, 1'b0);

    // reset during column-1 dwell with an event pending
    closed = 9'h001;
    run(4 * P);
    chk("d_valid_before", kif.key_valid, 1'b1);
    n = 0;
    while (col != 3'b101 && n < P) begin step(); n++; end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("d_col_idle", col, 3'b111);
    chk("d_outs_zero", {kstate, kpress, kif.key_valid, kif.key_code, kovf}, '0);
    step();
    chk("d_col0", col, 3'b110);
    closed = '0;

    // randomized patterns, acks and occasional resets against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        closed = '0;
        for (int k = 0; k < 9; k++)
          if ($urandom_range(0, 5) == 0) closed[k] = 1'b1;
      end
      kif.key_ack = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 1'b0;
    kif.key_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
